// File: rtl/fft_frame_pkg.sv
// fft_frame_pkg: shared types and default sizes for the FFT frame sequencer.
//   bank_state_t  - lifecycle of one ping-pong frame bank
//   FRAME_LEN_DEF - default samples per frame
//   DATA_W_DEF    - default sample width
package fft_frame_pkg;

  localparam int unsigned FRAME_LEN_DEF = 256;
  localparam int unsigned DATA_W_DEF    = 16;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_PROC
  } bank_state_t;

endpackage

// File: rtl/fft_frame_sequencer_if.sv
// fft_frame_sequencer_if: all non-clock/reset signals of the frame sequencer.
//   Receiver side : enable, sample_valid, sample_data, rx_sync_error
//   Bank writes   : wr_en, wr_bank, wr_addr, wr_data
//   FFT engine    : fft_start, fft_bank, fft_busy, fft_done
//   Status        : frame_count, drop_count, overrun, overrun_clr
// Modports: master = sequencer, slave = surrounding system / bench.
interface fft_frame_sequencer_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = fft_frame_pkg::DATA_W_DEF
);

  logic              enable;
  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic              rx_sync_error;

  logic              wr_en;
  logic              wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              fft_start;
  logic              fft_bank;
  logic              fft_busy;
  logic              fft_done;

  logic [15:0]       frame_count;
  logic [15:0]       drop_count;
  logic              overrun;
  logic              overrun_clr;

  modport master (
    input  enable, sample_valid, sample_data, rx_sync_error, fft_done, overrun_clr,
    output wr_en, wr_bank, wr_addr, wr_data, fft_start, fft_bank, fft_busy,
    output frame_count, drop_count, overrun
  );

  modport slave (
    output enable, sample_valid, sample_data, rx_sync_error, fft_done, overrun_clr,
    input  wr_en, wr_bank, wr_addr, wr_data, fft_start, fft_bank, fft_busy,
    input  frame_count, drop_count, overrun
  );

endinterface

// File: rtl/fft_sat_counter16.sv
// fft_sat_counter16: 16-bit event counter that saturates at 0xFFFF.
//   clk, reset : clock, asynchronous active-high reset
//   inc        : count one event
//   clr        : synchronous clear, wins over a same-cycle inc
//   count      : current value
module fft_sat_counter16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        clr,
  output logic [15:0] count
);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: ping-pong frame controller between the PCM1808 left-channel
// receiver and the FFT engine. Samples are written into the current fill bank; each
// completed bank is handed to the engine with a one-cycle fft_start and returned on
// fft_done. Samples arriving while the fill bank is still owned are dropped and counted.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : fft_frame_sequencer_if.master (receiver, bank write, engine, status)
// Optional build macro FFT_SYNC_ABORT_EN: rx_sync_error blocks sample acceptance and
// its rising edge discards a partially filled bank. Without it rx_sync_error is ignored.
module fft_frame_sequencer
  import fft_frame_pkg::*;
#(
  parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
  parameter int unsigned ADDR_W    = $clog2(FRAME_LEN),
  parameter int unsigned DATA_W    = DATA_W_DEF
) (
  input logic                   clk,
  input logic                   reset,
  fft_frame_sequencer_if.master bus
);

  // Bank bookkeeping
  bank_state_t       bank_q [2];
  bank_state_t       bank_d [2];
  logic              fill_q, fill_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Engine ownership
  logic              eng_active_q, eng_active_d;
  logic              done_seen_q;
  logic              fft_start_q;
  logic              fft_bank_q, fft_bank_d;
  logic              fft_busy_q, fft_busy_d;
  logic [15:0]       frame_count_q;

  // Registered write port
  logic              wr_en_q;
  logic              wr_bank_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic              overrun_q, overrun_d;

  // Decoded per-cycle events
  logic              accept_en;
  logic              abort;
  logic              fill_free;
  logic              accept;
  logic              drop;
  logic              last;
  logic              done_ok;
  logic              full0, full1;
  logic              start;
  logic              start_bank;

`ifdef FFT_SYNC_ABORT_EN
  logic              sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 1'b0;
    end else begin
      sync_q <= bus.rx_sync_error;
    end
  end
`else
  logic              unused_sync_error;
  assign unused_sync_error = bus.rx_sync_error;
`endif

  always_comb begin
    accept_en = bus.enable;
    abort     = 1'b0;
`ifdef FFT_SYNC_ABORT_EN
    if (bus.rx_sync_error) begin
      accept_en = 1'b0;
    end
    abort = bus.rx_sync_error & ~sync_q;
`endif
    fill_free = (bank_q[fill_q] == BANK_EMPTY) || (bank_q[fill_q] == BANK_FILLING);
    accept    = bus.sample_valid & accept_en & fill_free;
    drop      = bus.sample_valid & accept_en & ~fill_free;
    last      = accept && (addr_q == ADDR_W'(FRAME_LEN - 1));

    // A done while nothing is owned by the engine is meaningless and ignored.
    done_ok    = bus.fft_done & eng_active_q;
    full0      = (bank_q[0] == BANK_FULL);
    full1      = (bank_q[1] == BANK_FULL);
    start_bank = ~full0;
    // A done frees the engine in the same cycle so a waiting bank starts at M+1;
    // blocking behind fft_start_q keeps consecutive starts at least 2 cycles apart.
    start      = (full0 | full1) & (~eng_active_q | done_ok) & ~fft_start_q;
  end

  // Bank state, fill pointer and address. Accept/discard touch only the fill bank,
  // done only the PROC bank and start only a FULL bank, so all may apply together.
  always_comb begin
    bank_d[0]    = bank_q[0];
    bank_d[1]    = bank_q[1];
    fill_d       = fill_q;
    addr_d       = addr_q;
    eng_active_d = eng_active_q;
    fft_bank_d   = fft_bank_q;

    if (accept) begin
      bank_d[fill_q] = last ? BANK_FULL : BANK_FILLING;
      addr_d         = addr_q + ADDR_W'(1);
      if (last) begin
        fill_d = ~fill_q;
      end
    end else if (~bus.enable | abort) begin
      // Partial frames are never handed to the engine.
      addr_d = '0;
      if (bank_q[fill_q] == BANK_FILLING) begin
        bank_d[fill_q] = BANK_EMPTY;
      end
    end

    if (done_ok) begin
      bank_d[fft_bank_q] = BANK_EMPTY;
      eng_active_d       = 1'b0;
    end

    if (start) begin
      bank_d[start_bank] = BANK_PROC;
      eng_active_d       = 1'b1;
      fft_bank_d         = start_bank;
    end
  end

  // Busy rises the cycle after fft_start and falls two cycles after a done, unless
  // a back-to-back start at M+1 re-asserts it first.
  always_comb begin
    fft_busy_d = fft_busy_q;
    if (fft_start_q) begin
      fft_busy_d = 1'b1;
    end else if (done_seen_q) begin
      fft_busy_d = 1'b0;
    end
  end

  // Clear outranks a same-cycle drop.
  always_comb begin
    overrun_d = overrun_q;
    if (bus.overrun_clr) begin
      overrun_d = 1'b0;
    end else if (drop) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_q[0]     <= BANK_EMPTY;
      bank_q[1]     <= BANK_EMPTY;
      fill_q        <= 1'b0;
      addr_q        <= '0;
      eng_active_q  <= 1'b0;
      done_seen_q   <= 1'b0;
      fft_start_q   <= 1'b0;
      fft_bank_q    <= 1'b0;
      fft_busy_q    <= 1'b0;
      frame_count_q <= '0;
      overrun_q     <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_bank_q     <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
    end else begin
      bank_q[0]     <= bank_d[0];
      bank_q[1]     <= bank_d[1];
      fill_q        <= fill_d;
      addr_q        <= addr_d;
      eng_active_q  <= eng_active_d;
      done_seen_q   <= done_ok;
      fft_start_q   <= start;
      fft_bank_q    <= fft_bank_d;
      fft_busy_q    <= fft_busy_d;
      frame_count_q <= frame_count_q + 16'(start);
      overrun_q     <= overrun_d;
      wr_en_q       <= accept;
      if (accept) begin
        wr_bank_q <= fill_q;
        wr_addr_q <= addr_q;
        wr_data_q <= bus.sample_data;
      end
    end
  end

  fft_sat_counter16 u_drop_count (
    .clk   (clk),
    .reset (reset),
    .inc   (drop),
    .clr   (bus.overrun_clr),
    .count (bus.drop_count)
  );

  assign bus.wr_en       = wr_en_q;
  assign bus.wr_bank     = wr_bank_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.fft_start   = fft_start_q;
  assign bus.fft_bank    = fft_bank_q;
  assign bus.fft_busy    = fft_busy_q;
  assign bus.frame_count = frame_count_q;
  assign bus.overrun     = overrun_q;

endmodule
